// File: rtl/demux_1x8_reg.sv
// Registered 1-to-8 demultiplexer built from two gated 1-to-4 stages.
// The select {s1,s2,s3} steers `a` to one lane; every other lane is driven to zero.

module demux_1x4_stage #(
  parameter int WIDTH = 1
) (
  input  logic               en,
  input  logic [WIDTH-1:0]   a,
  input  logic [1:0]         sel,
  output logic [4*WIDTH-1:0] y
);

  logic [WIDTH-1:0] gated_s;

  // Gate the data by the stage enable, then place it in the selected lane
  always_comb begin
    gated_s = {WIDTH{1'b0}};
    y       = {(4*WIDTH){1'b0}};
    if (en) begin
      gated_s = a;
    end else begin
      gated_s = {WIDTH{1'b0}};
    end
    case (sel)
      2'd0:    y[0*WIDTH +: WIDTH] = gated_s;
      2'd1:    y[1*WIDTH +: WIDTH] = gated_s;
      2'd2:    y[2*WIDTH +: WIDTH] = gated_s;
      2'd3:    y[3*WIDTH +: WIDTH] = gated_s;
      default: y = {(4*WIDTH){1'b0}};
    endcase
  end

endmodule

module demux_1x8_reg #(
  parameter int WIDTH = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   a,
  input  logic               s1,
  input  logic               s2,
  input  logic               s3,
  output logic [8*WIDTH-1:0] out
);

  logic [4*WIDTH-1:0] lo_y_s;
  logic [4*WIDTH-1:0] hi_y_s;
  logic [8*WIDTH-1:0] out_d;
  logic [8*WIDTH-1:0] out_q;

  // Exactly one stage is enabled, so the two halves can never both be nonzero
  demux_1x4_stage #(.WIDTH(WIDTH)) u_lo (
    .en  (~s1),
    .a   (a),
    .sel ({s2, s3}),
    .y   (lo_y_s)
  );

  demux_1x4_stage #(.WIDTH(WIDTH)) u_hi (
    .en  (s1),
    .a   (a),
    .sel ({s2, s3}),
    .y   (hi_y_s)
  );

  // Concatenate the stage outputs into the next output word
  always_comb begin
    out_d = {hi_y_s, lo_y_s};
  end

  // Output register: captures every cycle, synchronous reset clears all lanes
  always_ff @(posedge clk) begin
    if (rst) begin
      out_q <= {(8*WIDTH){1'b0}};
    end else begin
      out_q <= out_d;
    end
  end

  assign out = out_q;

endmodule

// File: tb/tb_demux_1x8_reg.sv
// Self-checking bench for demux_1x8_reg: directed scenarios plus randomized
// stimulus on a WIDTH=1 and a WIDTH=4 instance against an arithmetic model.

module tb_demux_1x8_reg;

  localparam int W4 = 4;

  logic          clk;
  logic          rst;
  logic          a1;
  logic [W4-1:0] a4;
  logic          s1;
  logic          s2;
  logic          s3;
  logic [7:0]    out1;
  logic [8*W4-1:0] out4;

  int errors;
  int checks;

  demux_1x8_reg #(.WIDTH(1)) dut1 (
    .clk (clk),
    .rst (rst),
    .a   (a1),
    .s1  (s1),
    .s2  (s2),
    .s3  (s3),
    .out (out1)
  );

  demux_1x8_reg #(.WIDTH(W4)) dut4 (
    .clk (clk),
    .rst (rst),
    .a   (a4),
    .s1  (s1),
    .s2  (s2),
    .s3  (s3),
    .out (out4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: data shifted to lane sel, or zero under reset
  function automatic logic [7:0] model1(input logic r, input logic d, input int sel);
    logic [7:0] v;
    v = 8'd0;
    if (!r && d) v = 8'd1 << sel;
    return v;
  endfunction

  function automatic logic [8*W4-1:0] model4(input logic r, input logic [W4-1:0] d, input int sel);
    logic [8*W4-1:0] v;
    v = '0;
    if (!r) v = {{(7*W4){1'b0}}, d} << (sel * W4);
    return v;
  endfunction

  // Apply inputs, then advance past one rising edge and settle
  task automatic cyc(input logic r, input logic d, input int sel);
    rst = r;
    a1  = d;
    {s1, s2, s3} = sel[2:0];
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [7:0] exp;
    for (int i = 0; i < 2; i++) begin
      cyc(1'b1, 1'b1, 5);
      checks++;
      if (out1 !== 8'b00000000) begin
        errors++;
        $display("FAIL reset_hold cyc%0d: got %b expected %b", i, out1, 8'b00000000);
      end
    end
    cyc(1'b0, 1'b1, 5);
    exp = 8'b00100000;
    checks++;
    if (out1 !== exp) begin
      errors++;
      $display("FAIL reset_release: got %b expected %b", out1, exp);
    end
  endtask

  task automatic test_sweep();
    logic [7:0] exp;
    for (int s = 0; s < 8; s++) begin
      cyc(1'b0, 1'b1, s);
      exp = model1(1'b0, 1'b1, s);
      checks++;
      if (out1 !== exp) begin
        errors++;
        $display("FAIL sweep sel=%0d: got %b expected %b", s, out1, exp);
      end
    end
  endtask

  task automatic test_zero_data();
    for (int s = 0; s < 8; s++) begin
      cyc(1'b0, 1'b0, s);
      checks++;
      if (out1 !== 8'b00000000) begin
        errors++;
        $display("FAIL zero_data sel=%0d: got %b expected %b", s, out1, 8'b00000000);
      end
    end
  endtask

  task automatic test_stage_boundary();
    int sel;
    logic [7:0] exp;
    for (int i = 0; i < 6; i++) begin
      sel = (i % 2 == 0) ? 3 : 4;
      cyc(1'b0, 1'b1, sel);
      exp = (sel == 3) ? 8'b00001000 : 8'b00010000;
      checks++;
      if (out1 !== exp || (|out1[3:0] && |out1[7:4])) begin
        errors++;
        $display("FAIL boundary sel=%0d: got %b expected %b", sel, out1, exp);
      end
    end
  endtask

  task automatic test_latency();
    cyc(1'b0, 1'b1, 2);
    // Change data between edges: output must still hold the old value
    a1 = 1'b0;
    #2;
    checks++;
    if (out1 !== 8'b00000100) begin
      errors++;
      $display("FAIL latency_hold: got %b expected %b", out1, 8'b00000100);
    end
    @(posedge clk);
    #1;
    checks++;
    if (out1 !== 8'b00000000) begin
      errors++;
      $display("FAIL latency_drop: got %b expected %b", out1, 8'b00000000);
    end
  endtask

  task automatic test_mid_reset();
    logic [7:0] exp_seq [4];
    logic       rst_seq [4];
    exp_seq = '{8'b10000000, 8'b10000000, 8'b00000000, 8'b10000000};
    rst_seq = '{1'b0, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 4; i++) begin
      cyc(rst_seq[i], 1'b1, 7);
      checks++;
      if (out1 !== exp_seq[i]) begin
        errors++;
        $display("FAIL mid_reset step%0d: got %b expected %b", i, out1, exp_seq[i]);
      end
    end
  endtask

  task automatic test_random();
    logic          r;
    logic          d1;
    logic [W4-1:0] d4;
    int            sel;
    int            nz;
    logic [7:0]      exp1;
    logic [8*W4-1:0] exp4;
    for (int i = 0; i < 60; i++) begin
      r   = ($urandom_range(0, 9) == 0);
      d1  = 1'($urandom_range(0, 1));
      d4  = W4'($urandom);
      sel = $urandom_range(0, 7);
      a4  = d4;
      cyc(r, d1, sel);
      exp1 = model1(r, d1, sel);
      exp4 = model4(r, d4, sel);
      checks++;
      if (out1 !== exp1) begin
        errors++;
        $display("FAIL random_w1 i=%0d rst=%0b sel=%0d: got %b expected %b", i, r, sel, out1, exp1);
      end
      checks++;
      if (out4 !== exp4) begin
        errors++;
        $display("FAIL random_w4 i=%0d rst=%0b sel=%0d: got %h expected %h", i, r, sel, out4, exp4);
      end
      nz = 0;
      for (int k = 0; k < 8; k++) if (out4[k*W4 +: W4] != '0) nz++;
      checks++;
      if (nz > 1) begin
        errors++;
        $display("FAIL random_onelane i=%0d: got %0d nonzero lanes expected at most 1", i, nz);
      end
    end
    a4 = '0;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst = 1'b1;
    a1  = 1'b0;
    a4  = '0;
    {s1, s2, s3} = 3'd0;
    #1;
    test_reset();
    test_sweep();
    test_zero_data();
    test_stage_boundary();
    test_latency();
    test_mid_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/demux_1x8_reg.md
Name: demux_1x8_reg

Overview:
- Registered 1-to-8 demultiplexer: routes data input `a` to one of eight output lanes chosen by the 3-bit select {s1,s2,s3}; all other lanes are driven 0.
- Built hierarchically from two 1-to-4 demux stages. s1 picks the stage: s1=0 is the low stage for lanes 3..0, s1=1 is the high stage for lanes 7..4. {s2,s3} picks the lane within the stage.
- Used as a one-hot steering / decode element in datapath fan-out logic.

Parameters:
- WIDTH, 1, bit width of data input `a` and of each output lane.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- a  input  WIDTH  data to be routed.
- s1  input  1  select MSB; chooses the high or low 1:4 stage.
- s2  input  1  select middle bit.
- s3  input  1  select LSB.
- out  output  8*WIDTH  eight lanes; lane k occupies bits [k*WIDTH +: WIDTH].

Behaviour:
- Interface timing: one clock; reset is synchronous and active-high. All state updates on the rising edge of clk.
- Selection: sel = {s1,s2,s3}, an unsigned value 0..7.
  - The combinational next value places `a` in lane sel and zero in the other seven lanes.
  - s1=0: lanes 0..3 are indexed by {s2,s3}; lanes 4..7 are 0.
  - s1=1: lanes 4..7 are indexed by {s2,s3}; lanes 0..3 are 0.
- Sub-stages:
  - Each 1:4 stage receives `a` gated by its stage enable: low stage = ~s1, high stage = s1.
  - The disabled stage outputs all zeros.
- Output register: `out` is registered, with a latency of exactly 1 cycle from a/s1/s2/s3 to out.
  - No enable; the register captures every cycle.
- Reset:
  - When rst=1 at a rising edge, out becomes all zeros on that edge, regardless of a or select.
  - Reset dominates input changes in the same cycle.
  - On the first edge with rst=0, out reflects the current inputs.
- Invariants:
  - At most one lane is nonzero at any time.
  - If a=0, all of out is 0.
  - With WIDTH=1 and a=1, out is exactly one-hot: out == 1<<sel.
- Select changes: a change between edges has no effect until the next edge; no glitches appear on out.
- X/Z on select inputs is not supported; no defined behaviour is required.

Test Plan:
- Reset: assert rst with a=1, sel=5 for 2 cycles -> out=8'b00000000. Release rst -> next edge out=8'b00100000.
- Sweep: WIDTH=1, a=1, sel stepped 0..7, one per cycle -> out one cycle later = 00000001, 00000010, 00000100, 00001000, 00010000, 00100000, 01000000, 10000000.
- Zero data: a=0, sweep sel 0..7 -> out=8'b00000000 on every cycle.
- Stage boundary: alternate sel 3 <-> 4 each cycle with a=1 -> out alternates 00001000 / 00010000. Confirm the low and high stages never drive simultaneously.
- Latency: hold sel=2 and change a 1->0 at a cycle boundary -> out lane 2 drops exactly one edge later.
- Mid-operation reset: a=1, sel=7 running, pulse rst for one cycle -> out=0 for that edge only, then 10000000 resumes.
